eth_drp_master: RTL and testbench
=================================

Name: eth_drp_master

Overview:
- Single-initiator DRP access engine that drives the DRP port of the Ethernet transceiver/PHY wrapper (drpen/drpwe/drpaddr/drpdi in; drpdo/drprdy out).
- Converts a valid/ready register request stream, from the control-register bridge, into exactly one DRP transaction at a time.
- Returns read data or a timeout indication on a valid/ready response channel.
- Sits in the Ethernet clock domain; the DRP clock of the wrapper is driven by the same clk.

Parameters:
- ADDR_WIDTH, 10, DRP address width.
- DATA_WIDTH, 16, DRP data width.
- TIMEOUT_CYCLES, 255, cycles after the drpen pulse to wait for drprdy before aborting; legal range 2..65535.
- TIMEOUT_DATA, 16'hDEAD, rsp_rdata value returned on timeout.

Ports:
- clk  in  1  DRP/system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  DRP address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for a completed write; TIMEOUT_DATA on timeout.
- rsp_timeout  out  1  response was produced by timeout.
- stray_rdy  out  1  one-cycle pulse: drprdy seen while no access is outstanding.
- drpen_out  out  1  DRP enable (single-cycle pulse).
- drpwe_out  out  1  DRP write enable.
- drpaddr_out  out  ADDR_WIDTH  DRP address.
- drpdi_out  out  DATA_WIDTH  DRP write data.
- drpdo_in  in  DATA_WIDTH  DRP read data.
- drprdy_in  in  1  DRP ready.

Behaviour:
- Reset values: every output is 0, except drpaddr_out and drpdi_out, which hold 0. The FSM returns to IDLE.
- Reset asserted mid-access: the outstanding access is abandoned; drpen_out is 0 on the next edge; no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On accept, register addr, wdata and write, then go to ISSUE.
- ISSUE (one cycle):
  - drpen_out = 1 and drpwe_out = req_write. drpaddr_out/drpdi_out are valid and held stable until the next accept.
  - Load the timeout counter with 0, then go to WAIT.
- WAIT:
  - drpen_out = 0 and drpwe_out = 0.
  - The counter increments each cycle.
  - If drprdy_in = 1: capture drpdo_in (reads) or 0 (writes), set rsp_timeout = 0, go to RESP.
  - Else, when the counter equals TIMEOUT_CYCLES-1: set rsp_rdata = TIMEOUT_DATA and rsp_timeout = 1, go to RESP.
  - drprdy_in in the same cycle as expiry: drprdy wins (normal completion).
- RESP:
  - rsp_valid = 1; rsp_rdata/rsp_timeout are held stable until the handshake.
  - On rsp_ready, go to IDLE. req_ready becomes 1 the cycle after the handshake; there is no back-to-back overlap.
- Latency:
  - Accept at cycle 0; drpen at cycle 1.
  - drprdy at cycle 1+k (k ≥ 1) gives rsp_valid at cycle 2+k.
  - Timeout gives rsp_valid at cycle 2+TIMEOUT_CYCLES.
- drprdy_in in IDLE, ISSUE or RESP is ignored for data and pulses stray_rdy for one cycle. This covers a late ready after a timeout.
- Exactly one drpen pulse per accepted request (one read plus one write in RMW mode); drpen is never asserted outside ISSUE.

Optional Feature:
- Macro: DRP_RMW_EN.
- Enabled:
  - Adds the input port req_mask [DATA_WIDTH].
  - Writes with req_mask != all-ones run as read-modify-write: ISSUE(read) → WAIT → ISSUE(write) → WAIT → RESP.
  - Write data = (read & ~mask) | (wdata & mask); rsp_rdata returns the pre-modify read value.
  - A timeout on either phase terminates immediately with a timeout response; the write phase is not issued if the read timed out.
  - Writes with mask all-ones and all reads behave as in the base design.
- Disabled: no req_mask port; all writes are plain single-phase writes.

Decomposition:
- Package eth_drp_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, RESP, plus RMW phase flag encoding);
  - DRP_ADDR_WIDTH and DRP_DATA_WIDTH defaults;
  - the default TIMEOUT_DATA constant.
- One natural sub-module: eth_drp_timeout, a loadable up-counter with expiry flag, parameterised by TIMEOUT_CYCLES and sized $clog2(TIMEOUT_CYCLES+1).
- Everything else is inline.

Test Plan:
- Read addr 10'h03C; model returns drprdy 3 cycles after drpen with drpdo = 16'hA5C3 → exactly one drpen pulse with drpwe = 0 and addr 10'h03C; rsp_valid 4 cycles after drpen; rsp_rdata = 16'hA5C3; rsp_timeout = 0.
- Write addr 10'h111 data 16'h1234; rdy after 1 cycle → drpen and drpwe high for one cycle; drpdi = 16'h1234; rsp_rdata = 0.
- Model never asserts rdy, TIMEOUT_CYCLES = 8 → rsp_valid at cycle 10 after accept with rdata = 16'hDEAD and timeout = 1; a late rdy then pulses stray_rdy with no second response.
- Hold rsp_ready low for 5 cycles while req_valid stays high → req_ready stays 0 and the response stays stable; the next drpen comes only after the handshake.
- Assert rst in WAIT → drpen stays 0, rsp_valid stays 0, req_ready = 1 after reset deasserts; a new read completes normally.
- DRP_RMW_EN: register holds 16'hFF00; write wdata 16'h00AA with mask 16'h00FF → read then write; drpdi = 16'hFFAA; rsp_rdata = 16'hFF00; two drpen pulses total.

Source files
------------

// File: rtl/eth_drp_pkg.sv
// Shared types and defaults for the Ethernet DRP access engine.
// The optional read-modify-write path is enabled with DRP_RMW_EN.
package eth_drp_pkg;

    localparam int          DRP_ADDR_WIDTH   = 10;
    localparam int          DRP_DATA_WIDTH   = 16;
    localparam logic [15:0] DRP_TIMEOUT_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } drp_state_e;

    // Which half of a read-modify-write is outstanding.
    typedef enum logic {
        PH_READ  = 1'b0,
        PH_WRITE = 1'b1
    } drp_phase_e;

endpackage

// File: rtl/eth_drp_timeout.sv
// Loadable up-counter that flags expiry once TIMEOUT_CYCLES-1 is reached.
// Saturates at expiry so an extended wait never wraps back to a live count.
module eth_drp_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired_o = (count_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/eth_drp_master.sv
// Single-outstanding DRP access engine: request stream in, one DRP access, response out.
// Define DRP_RMW_EN to add req_mask and masked writes as read-modify-write.
module eth_drp_master
    import eth_drp_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = DRP_ADDR_WIDTH,
    parameter int                    DATA_WIDTH     = DRP_DATA_WIDTH,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(DRP_TIMEOUT_DATA)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
`ifdef DRP_RMW_EN
    input  logic [DATA_WIDTH-1:0] req_mask,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  stray_rdy,
    output logic                  drpen_out,
    output logic                  drpwe_out,
    output logic [ADDR_WIDTH-1:0] drpaddr_out,
    output logic [DATA_WIDTH-1:0] drpdi_out,
    input  logic [DATA_WIDTH-1:0] drpdo_in,
    input  logic                  drprdy_in
);

    drp_state_e            state_q;
    drp_state_e            state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] wait_data;
    logic                  write_q;
    logic                  timeout_q;
    logic                  stray_q;
    logic                  accept;
    logic                  expired;
    logic                  rmw_read_phase;

`ifdef DRP_RMW_EN
    logic                  rmw_q;
    drp_phase_e            phase_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [DATA_WIDTH-1:0] merged;

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_merge
        assign merged[gi] = mask_q[gi] ? wdata_q[gi] : drpdo_in[gi];
    end

    assign rmw_read_phase = rmw_q && (phase_q == PH_READ);
    // The write phase keeps the pre-modify value captured by the read phase.
    assign wait_data = rmw_q ? (rmw_read_phase ? drpdo_in : rdata_q)
                             : (write_q ? '0 : drpdo_in);
`else
    assign rmw_read_phase = 1'b0;
    assign wait_data      = write_q ? '0 : drpdo_in;
`endif

    assign accept      = req_valid && req_ready;
    assign drpaddr_out = addr_q;
    assign drpdi_out   = wdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_timeout = timeout_q;
    assign stray_rdy   = stray_q;

    eth_drp_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .load_i    (state_q == ST_ISSUE),
        .en_i      (state_q == ST_WAIT),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // A ready arriving on the expiry cycle still counts as completion.
                if (drprdy_in) begin
                    state_d = rmw_read_phase ? ST_ISSUE : ST_RESP;
                end else if (expired) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE) && !rst;
        drpen_out = (state_q == ST_ISSUE);
        drpwe_out = (state_q == ST_ISSUE) && write_q && !rmw_read_phase;
        rsp_valid = (state_q == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            stray_q   <= 1'b0;
`ifdef DRP_RMW_EN
            rmw_q     <= 1'b0;
            phase_q   <= PH_READ;
            mask_q    <= '0;
`endif
        end else begin
            stray_q <= drprdy_in && (state_q != ST_WAIT);
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                write_q <= req_write;
`ifdef DRP_RMW_EN
                rmw_q   <= req_write && (req_mask != '1);
                phase_q <= PH_READ;
                mask_q  <= req_mask;
`endif
            end
            if (state_q == ST_WAIT) begin
                if (drprdy_in) begin
                    rdata_q   <= wait_data;
                    timeout_q <= 1'b0;
`ifdef DRP_RMW_EN
                    if (rmw_read_phase) begin
                        wdata_q <= merged;
                        phase_q <= PH_WRITE;
                    end
`endif
                end else if (expired) begin
                    rdata_q   <= TIMEOUT_DATA;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_drp_master.sv
// Scoreboard bench for eth_drp_master: directed cases, then randomized traffic
// against a memory-backed DRP slave and an access-level reference model.
module tb_eth_drp_master;

    localparam int          AW    = 10;
    localparam int          DW    = 16;
    localparam int          TO    = 8;
    localparam logic [15:0] TDATA = 16'hDEAD;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, req_mask;
    logic          rsp_valid, rsp_ready, rsp_timeout, stray_rdy;
    logic [DW-1:0] rsp_rdata;
    logic          drpen_out, drpwe_out, drprdy_in;
    logic [AW-1:0] drpaddr_out;
    logic [DW-1:0] drpdi_out, drpdo_in;

    always #5 clk = ~clk;

    eth_drp_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_DATA   (TDATA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
`ifdef DRP_RMW_EN
        .req_mask    (req_mask),
`endif
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .stray_rdy   (stray_rdy),
        .drpen_out   (drpen_out),
        .drpwe_out   (drpwe_out),
        .drpaddr_out (drpaddr_out),
        .drpdi_out   (drpdi_out),
        .drpdo_in    (drpdo_in),
        .drprdy_in   (drprdy_in)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        to;
        int          acc;
        int          lat;
    } rsp_t;

    typedef struct {
        logic       we;
        logic [9:0] addr;
        logic [15:0] di;
        int         dly;
    } op_t;

    rsp_t        rsp_q[$];
    op_t         op_q[$];
    bit [15:0]   ref_mem[1024];
    bit [15:0]   slv_mem[1024];
    int          cyc       = 0;
    int          checks    = 0;
    int          failures  = 0;
    int          stray_cnt = 0;
    int          stray_inj = 0;
    int          drpen_cnt = 0;
    int          rsp_hold  = 0;
    bit          rnd_bp    = 0;
    bit          stray_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // DRP slave: checks each drpen against the expected access, answers after its delay.
    initial begin
        int  rdy_at;
        op_t cur;
        rdy_at    = -1;
        cur       = '{1'b0, 10'h0, 16'h0, 0};
        drprdy_in = 1'b0;
        drpdo_in  = '0;
        forever begin
            @(negedge clk);
            drprdy_in = 1'b0;
            drpdo_in  = 16'($urandom);
            if (stray_rdy) stray_cnt++;
            if (drpen_out) begin
                drpen_cnt++;
                if (op_q.size() == 0) begin
                    chk("drpen_unexpected", 32'd1, 32'd0);
                end else begin
                    cur = op_q.pop_front();
                    chk("drpwe", 32'(drpwe_out), 32'(cur.we));
                    chk("drpaddr", 32'(drpaddr_out), 32'(cur.addr));
                    if (cur.we) chk("drpdi", 32'(drpdi_out), 32'(cur.di));
                    rdy_at = (cur.dly > 0) ? cyc + cur.dly : -1;
                end
            end else begin
                chk("drpwe_outside_issue", 32'(drpwe_out), 32'd0);
            end
            if (cyc == rdy_at) begin
                drprdy_in = 1'b1;
                drpdo_in  = slv_mem[cur.addr];
                if (cur.we) slv_mem[cur.addr] = cur.di;
                rdy_at = -1;
            end else if (stray_req) begin
                drprdy_in = 1'b1;
                stray_req = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard on each handshake and drives rsp_ready.
    initial begin
        bit          seen;
        logic [15:0] hd;
        logic        ht;
        rsp_t        e;
        bit          rr;
        seen      = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen      = 0;
                rsp_ready = 1'b0;
            end else if (rsp_valid) begin
                chk("req_ready_during_resp", 32'(req_ready), 32'd0);
                if (!seen) begin
                    seen = 1;
                    hd   = rsp_rdata;
                    ht   = rsp_timeout;
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = rsp_q[0];
                        chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                    end
                end else begin
                    chk("rsp_rdata_stable", 32'(rsp_rdata), 32'(hd));
                    chk("rsp_timeout_stable", 32'(rsp_timeout), 32'(ht));
                end
                if (rsp_hold > 0) begin
                    rsp_hold--;
                    rr = 0;
                end else begin
                    rr = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                rsp_ready = rr;
                if (rr) begin
                    seen = 0;
                    if (rsp_q.size() > 0) void'(rsp_q.pop_front());
                end
            end else begin
                seen      = 0;
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Issue one request; on acceptance, push what the reference model expects.
    task automatic send(input logic we, input logic [9:0] a, input logic [15:0] wd,
                        input logic [15:0] mask, input int dly, input bit expect_rsp);
        int          n;
        rsp_t        e;
        logic [15:0] old;
        logic [15:0] merged;
        bit          rmw;
        bit          to;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = we;
        req_addr  = a;
        req_wdata = wd;
        req_mask  = mask;
        while (!req_ready) begin
            if (n++ > 200) begin
                chk("req_accept_wait", 32'd0, 32'd1);
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        to = (dly == 0);
`ifdef DRP_RMW_EN
        rmw = we && (mask != 16'hFFFF);
`else
        rmw = 0;
`endif
        old   = ref_mem[a];
        e.acc = cyc;
        e.to  = to;
        e.lat = to ? 2 + TO : 2 + dly;
        if (!we) begin
            op_q.push_back('{1'b0, a, 16'h0, dly});
            e.rdata = to ? TDATA : old;
        end else if (!rmw) begin
            op_q.push_back('{1'b1, a, wd, dly});
            e.rdata = to ? TDATA : 16'h0;
            if (!to) ref_mem[a] = wd;
        end else begin
            op_q.push_back('{1'b0, a, 16'h0, dly});
            if (to) begin
                e.rdata = TDATA;
            end else begin
                merged = (old & ~mask) | (wd & mask);
                op_q.push_back('{1'b1, a, merged, dly});
                ref_mem[a] = merged;
                e.rdata    = old;
                e.lat      = 2 * dly + 3;
            end
        end
        if (expect_rsp) rsp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(rsp_q.size() == 0 && op_q.size() == 0 && req_ready)) begin
            if (n++ > 500) begin
                chk("idle_wait", 32'd0, 32'd1);
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_mask  = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_stray_rdy", 32'(stray_rdy), 32'd0);
        chk("rst_drpen", 32'(drpen_out), 32'd0);
        chk("rst_drpaddr", 32'(drpaddr_out), 32'd0);
        chk("rst_drpdi", 32'(drpdi_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);

        ref_mem[10'h03C] = 16'hA5C3;
        slv_mem[10'h03C] = 16'hA5C3;
        send(1'b0, 10'h03C, 16'h0, 16'hFFFF, 3, 1);
        wait_idle();
        send(1'b1, 10'h111, 16'h1234, 16'hFFFF, 1, 1);
        wait_idle();

        // Timeout, then a late ready that must only raise stray_rdy.
        send(1'b0, 10'h200, 16'h0, 16'hFFFF, 0, 1);
        wait_idle();
        stray_inj++;
        stray_req = 1;
        repeat (4) @(negedge clk);
        chk("stray_after_timeout", 32'(stray_cnt), 32'(stray_inj));

        // Ready landing on the expiry cycle completes normally.
        send(1'b0, 10'h111, 16'h0, 16'hFFFF, TO, 1);
        wait_idle();

        // Response backpressure with a second request already waiting.
        rsp_hold = 5;
        send(1'b0, 10'h03C, 16'h0, 16'hFFFF, 1, 1);
        send(1'b1, 10'h03C, 16'h5A5A, 16'hFFFF, 2, 1);
        wait_idle();

        // Reset during WAIT abandons the access without a response.
        send(1'b0, 10'h2A0, 16'h0, 16'hFFFF, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_wait_drpen", 32'(drpen_out), 32'd0);
            chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wait_req_ready", 32'(req_ready), 32'd1);
        send(1'b0, 10'h03C, 16'h0, 16'hFFFF, 2, 1);
        wait_idle();

`ifdef DRP_RMW_EN
        ref_mem[10'h050] = 16'hFF00;
        slv_mem[10'h050] = 16'hFF00;
        d0 = drpen_cnt;
        send(1'b1, 10'h050, 16'h00AA, 16'h00FF, 2, 1);
        wait_idle();
        chk("rmw_drpen_pulses", 32'(drpen_cnt - d0), 32'd2);
        chk("rmw_slave_value", 32'(slv_mem[10'h050]), 32'hFFAA);
`endif

        rnd_bp = 1;
        for (int t = 0; t < 40; t++) begin
            logic [15:0] m;
            int          dly;
            m   = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
            dly = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
            send(1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), 16'($urandom), m, dly, 1);
        end
        wait_idle();
        rnd_bp = 0;

        d0 = drpen_cnt;
        repeat (3) @(negedge clk);
        chk("no_idle_drpen", 32'(drpen_cnt - d0), 32'd0);
        chk("drp_ops_left", 32'(op_q.size()), 32'd0);
        chk("rsp_left", 32'(rsp_q.size()), 32'd0);
        chk("stray_total", 32'(stray_cnt), 32'(stray_inj));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
